// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit
//
// Purpose: executes MULT/MULTU/DIV/DIVU one radix-2 step per clock and holds the
//          result in HI/LO for MFHI/MFLO. MTHI/MTLO write HI/LO directly while idle.
// Ports:   clock, reset (sync, active-high)
//          start, op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), operandA, operandB
//          writeHi, writeLo, writeData     MTHI/MTLO
//          busy, done, hi, lo              status and HI/LO registers
// Config:  MULDIV_FAST_MULT_EN - MULT/MULTU finish in a single step using '*'.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [W2-1:0]     acc_q;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]  opnd_q;      // mult: multiplicand magnitude; div: divisor magnitude
    logic              is_div_q;
    logic              neg_q;       // result sign flip (signA ^ signB)
    logic              sign_a_q;    // remainder follows dividend sign
    logic              div_zero_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              busy_q, done_q;

    // operand preparation at accept time
    logic              sign_a, sign_b;
    logic [WIDTH-1:0]  mag_a, mag_b;

    // one iteration step and final result formatting
    logic [WIDTH:0]    add_sum, shifted, diff;
    logic [W2-1:0]     acc_d, prod;
    logic [WIDTH-1:0]  quo, rem, res_hi_d, res_lo_d;
    logic              last_step;

    always_comb begin
        sign_a = ~op[0] & operandA[WIDTH-1];
        sign_b = ~op[0] & operandB[WIDTH-1];
        mag_a  = sign_a ? -operandA : operandA;
        mag_b  = sign_b ? -operandB : operandB;
    end

    always_comb begin
        add_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        shifted = acc_q[W2-1:WIDTH-1];
        diff    = shifted - {1'b0, opnd_q};
        if (is_div_q) begin
            // restoring division: keep the difference only when it did not go negative
            if (diff[WIDTH])
                acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            else
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
`ifdef MULDIV_FAST_MULT_EN
        if (!is_div_q)
            acc_d = W2'(opnd_q) * W2'(acc_q[WIDTH-1:0]);
        last_step = !is_div_q || (cnt_q == CW'(WIDTH - 1));
`else
        last_step = (cnt_q == CW'(WIDTH - 1));
`endif
        prod = neg_q ? -acc_d : acc_d;
        quo  = acc_d[WIDTH-1:0];
        rem  = acc_d[W2-1:WIDTH];
        if (is_div_q) begin
            // a zero divisor leaves |A| in the remainder, so re-signing it restores A
            res_lo_d = div_zero_q ? '1 : (neg_q ? -quo : quo);
            res_hi_d = sign_a_q ? -rem : rem;
        end else begin
            res_lo_d = prod[WIDTH-1:0];
            res_hi_d = prod[W2-1:WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        is_div_q   <= op[1];
                        neg_q      <= sign_a ^ sign_b;
                        sign_a_q   <= sign_a;
                        div_zero_q <= (operandB == '0);
                        opnd_q     <= op[1] ? mag_b : mag_a;
                        acc_q      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                    end else begin
                        if (writeHi) hi_q <= writeData;
                        if (writeLo) lo_q <= writeData;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = '0, operandB = '0;
    logic        writeHi = 1'b0, writeLo = 1'b0;
    logic [31:0] writeData = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];
    int stray_done = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .writeHi(writeHi), .writeLo(writeLo), .writeData(writeData),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops an expected {hi,lo} on each done pulse
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            done_prev = 1'b0;
        end else begin
            if (done) begin
                if (done_prev) check("done_width", 64'd2, 64'd1);
                if (sb_q.size() == 0) begin
                    stray_done++;
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("result_hilo", {hi, lo}, sb_q.pop_front());
                end
            end
            done_prev = done;
        end
    end

    // mode: 0 plain, 1 writeLo with start, 2 writeLo while busy, 3 restart at cycle 5
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int mode, input logic [31:0] exp_lo_run);
        int busy_cnt = 0;
        int guard = 0;
        int lat;
        lat = 32;
`ifdef MULDIV_FAST_MULT_EN
        if (!o[1]) lat = 1;
`endif
        @(negedge clock);
        start = 1'b1; op = o; operandA = a; operandB = b;
        if (mode == 1) begin writeLo = 1'b1; writeData = 32'hDEADBEEF; end
        sb_q.push_back({eh, el});
        @(negedge clock);
        start = 1'b0; writeLo = 1'b0;
        operandA = 32'h0BAD0BAD; operandB = 32'h0BAD0BAD;
        if (mode == 1) check("wlo_with_start", {32'd0, lo}, {32'd0, exp_lo_run});
        while (busy === 1'b1 && guard < 200) begin
            busy_cnt++;
            if (mode == 2 && busy_cnt == 3) begin writeLo = 1'b1; writeData = 32'hCAFEF00D; end
            if (mode == 3 && busy_cnt == 5) begin
                start = 1'b1; op = 2'b01; operandA = 32'hFFFFFFFF; operandB = 32'hFFFFFFFF;
            end
            @(negedge clock);
            if (mode == 2 && busy_cnt == 3) begin
                writeLo = 1'b0;
                check("wlo_while_busy", {32'd0, lo}, {32'd0, exp_lo_run});
            end
            if (mode == 3 && busy_cnt == 5) start = 1'b0;
            guard++;
        end
        if (guard >= 200) check("busy_timeout", 64'd1, 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(lat));
    endtask

    initial begin
        int dones;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);

        // idle MTHI / MTLO
        writeHi = 1'b1; writeData = 32'hA5A5A5A5;
        @(negedge clock);
        writeHi = 1'b0;
        check("mthi", {hi, lo}, {32'hA5A5A5A5, 32'h0});
        writeHi = 1'b1; writeLo = 1'b1; writeData = 32'h5A5A5A5A;
        @(negedge clock);
        writeHi = 1'b0; writeLo = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'h5A5A5A5A, 32'h5A5A5A5A});

        do_op(2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 1, 32'h5A5A5A5A);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 2, 32'd12);
        do_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 32'h0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 32'h0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 32'h0);
        do_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 32'h0);
        do_op(2'b11, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 32'h0);
        do_op(2'b10, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, 32'h0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 32'h0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, 32'h0);
        do_op(2'b01, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 0, 32'h0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 3, 32'h0);

        // reset in the middle of an operation: no result, no done
        @(negedge clock);
        start = 1'b1; op = 2'b11; operandA = 32'd1000; operandB = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
